// File: rtl/ssram_ctrl.sv
// SSRAM controller: valid/ready requests onto a 1-cycle-latency SRAM,
// read data bypasses to the initiator or parks in a 2-entry response FIFO.
module ssram_ctrl #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    input  logic [WIDTH/8-1:0]   req_be,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic                 idle,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic [WIDTH-1:0]     mem_write_data,
    output logic [WIDTH/8-1:0]   mem_write_byte_enable,
    output logic                 mem_write_enable,
    output logic                 mem_read_enable,
    input  logic [WIDTH-1:0]     mem_read_data
);

    logic             in_flight;
    logic [WIDTH-1:0] fifo_q [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic [1:0]       occupancy;
    logic             fifo_empty;
    logic             hs;
    logic             push;
    logic             pop;

    assign fifo_empty = (count == 2'd0);
    assign occupancy  = count + {1'b0, in_flight};
    assign req_ready  = rst && (occupancy < 2'd2);
    assign idle       = (occupancy == 2'd0);
    assign hs         = req_valid && req_ready;

    assign mem_address           = req_addr;
    assign mem_write_data        = req_wdata;
    assign mem_write_byte_enable = req_be;
    assign mem_write_enable      = hs && req_write;
    assign mem_read_enable       = hs && !req_write;

    // FIFO head has priority; returning data is only shown directly when FIFO is empty
    assign rsp_valid = !fifo_empty || in_flight;
    always_comb begin
        rsp_rdata = '0;
        if (!fifo_empty)
            rsp_rdata = fifo_q[rd_ptr];
        else if (in_flight)
            rsp_rdata = mem_read_data;
    end

    assign pop  = !fifo_empty && rsp_ready;
    assign push = in_flight && !(fifo_empty && rsp_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            in_flight <= hs && !req_write;
            if (push) begin
                fifo_q[wr_ptr] <= mem_read_data;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ssram_ctrl.sv
// Bench for ssram_ctrl: SRAM model, request driver, and a scoreboard
// monitor that checks every read response against queued expectations.
module tb_ssram_ctrl;

    localparam int W  = 32;
    localparam int AB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AB-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic [W/8-1:0] req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_rdata;
    logic          idle;
    logic [AB-1:0] mem_address;
    logic [W-1:0]  mem_write_data;
    logic [W/8-1:0] mem_write_byte_enable;
    logic          mem_write_enable;
    logic          mem_read_enable;
    logic [W-1:0]  mem_read_data;

    always #5 clk = ~clk;

    ssram_ctrl #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_be(req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .idle(idle),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_write_byte_enable(mem_write_byte_enable),
        .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable),
        .mem_read_data(mem_read_data)
    );

    logic [31:0] sram    [256];
    logic [31:0] ref_mem [256];
    logic [31:0] expq [$];
    int          checks = 0;
    int          errors = 0;
    logic        held_v = 1'b0;
    logic [31:0] held_d = '0;
    bit          rand_rdy = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_write_enable)
            sram[mem_address[7:0]] <= merge(sram[mem_address[7:0]],
                                            mem_write_data, mem_write_byte_enable);
        if (mem_read_enable)
            mem_read_data <= sram[mem_address[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (mem_write_enable || mem_read_enable) begin
                chk("enable_exclusive",
                    {31'b0, mem_write_enable && mem_read_enable}, 0);
                chk("enable_needs_hs",
                    {31'b0, req_valid && req_ready &&
                     (mem_write_enable ? req_write : !req_write)}, 1);
            end
            if (held_v) begin
                chk("rsp_hold_valid", {31'b0, rsp_valid}, 1);
                chk("rsp_hold_data", rsp_rdata, held_d);
            end
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got data %h, expected no response",
                             rsp_rdata);
                end else begin
                    chk("rsp_data", rsp_rdata, expq.pop_front());
                end
            end
            held_v = rsp_valid && !rsp_ready;
            held_d = rsp_rdata;
        end else begin
            held_v = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic issue(input bit w, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] exp,
                         output int waited);
        waited    = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        @(negedge clk);
        while (!req_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: req_ready got 0, expected 1");
        end else if (w) begin
            ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], d, be);
        end else begin
            expq.push_back(exp);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int wt;
        for (int i = 0; i < 256; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        mem_read_data = '0;
        rst       = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_idle", {31'b0, idle}, 1);
        chk("rst_we", {31'b0, mem_write_enable}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        req_write = 1'b0;
        #1;
        chk("rst_re", {31'b0, mem_read_enable}, 0);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'b0, req_ready}, 1);
        chk("post_rst_idle", {31'b0, idle}, 1);

        issue(1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, wt);
        issue(0, 16'h0010, 0, 0, 32'hDEADBEEF, wt);
        @(negedge clk);
        chk("read_latency_1", {31'b0, rsp_valid}, 1);
        @(posedge clk);
        #1;
        issue(1, 16'h0010, 32'h11223344, 4'h5, 0, wt);
        issue(0, 16'h0010, 0, 0, 32'hDE22BE44, wt);
        @(negedge clk);
        chk("read_latency_2", {31'b0, rsp_valid}, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++)
            issue(1, 16'(i), 32'hC0DE0000 + i, 4'hF, 0, wt);
        for (int i = 0; i < 4; i++) begin
            issue(0, 16'(i), 0, 0, 32'hC0DE0000 + i, wt);
            if (i > 0) chk("b2b_no_wait", wt, 0);
        end
        chk("b2b_consecutive", expq.size(), 1);
        @(negedge clk);
        chk("b2b_last_valid", {31'b0, rsp_valid}, 1);
        @(posedge clk);
        #1;

        rsp_ready = 1'b0;
        issue(0, 16'h0000, 0, 0, 32'hC0DE0000, wt);
        issue(0, 16'h0001, 0, 0, 32'hC0DE0001, wt);
        chk("stall_second_no_wait", wt, 0);
        chk("stall_ready_low", {31'b0, req_ready}, 0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0002;
        repeat (3) begin
            @(negedge clk);
            chk("stall_blocked", {31'b0, req_ready}, 0);
            chk("stall_no_read", {31'b0, mem_read_enable}, 0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_ready_before_pop", {31'b0, req_ready}, 0);
        @(posedge clk);
        #1;
        chk("ready_after_pop", {31'b0, req_ready}, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_drained", expq.size(), 0);

        rsp_ready = 1'b0;
        issue(0, 16'h0003, 0, 0, 32'hC0DE0003, wt);
        rst = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("mid_rst_idle", {31'b0, idle}, 1);
        chk("mid_rst_ready", {31'b0, req_ready}, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        expq.delete();
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("after_rst_idle", {31'b0, idle}, 1);
        chk("after_rst_no_rsp", {31'b0, rsp_valid}, 0);
        chk("after_rst_ready", {31'b0, req_ready}, 1);

        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            bit          w;
            logic [15:0] a;
            logic [31:0] d;
            logic [3:0]  be;
            w  = 1'($urandom_range(0, 1));
            a  = 16'($urandom_range(0, 7));
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            issue(w, a, d, be, ref_mem[a[7:0]], wt);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        for (int n = 0; n < 200 && expq.size() != 0; n++)
            @(posedge clk);
        #1;
        chk("random_drain", expq.size(), 0);
        @(posedge clk);
        #1;
        chk("final_idle", {31'b0, idle}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssram_ctrl.md
SSRAM_CTRL -- requirements
Module: ssram_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits, multiple of 8.
REQ-002 Parameter ADDR_BITS, default 16, word address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 req_valid  input  1  initiator request valid.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_BITS  word address.
REQ-009 req_wdata  input  WIDTH  write data.
REQ-010 req_be  input  WIDTH/8  byte enables for writes; bit i covers bits [8i+7:8i].
REQ-011 rsp_valid  output  1  read response valid.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  WIDTH  read response data.
REQ-014 idle  output  1  no read in flight and response buffer empty.
REQ-015 mem_address  output  ADDR_BITS  SRAM address.
REQ-016 mem_write_data  output  WIDTH  SRAM write data.
REQ-017 mem_write_byte_enable  output  WIDTH/8  SRAM byte enables.
REQ-018 mem_write_enable  output  1  SRAM write strobe.
REQ-019 mem_read_enable  output  1  SRAM read strobe.
REQ-020 mem_read_data  input  WIDTH  SRAM registered read data, valid the cycle after mem_read_enable.

Function
REQ-021 A request SHALL be accepted in a cycle with req_valid=1 and req_ready=1 (handshake); req_ready SHALL NOT depend on req_valid or req_write.
REQ-022 On handshake, mem_address=req_addr, mem_write_data=req_wdata, mem_write_byte_enable=req_be, combinationally in the same cycle.
REQ-023 mem_write_enable SHALL be 1 only in a write handshake cycle; mem_read_enable SHALL be 1 only in a read handshake cycle; both 0 otherwise.
REQ-024 Writes SHALL complete on handshake and generate no response.
REQ-025 Occupancy = response FIFO entries (0..2) + in-flight read flag (0/1); req_ready SHALL be 1 iff occupancy < 2.
REQ-026 A read accepted in cycle T SHALL set the in-flight flag; mem_read_data SHALL be sampled as that read's data in cycle T+1.
REQ-027 Bypass: in cycle T+1, if FIFO is empty, rsp_valid=1 and rsp_rdata=mem_read_data; if rsp_ready=1 the data is consumed, else it is pushed into the FIFO at end of T+1.
REQ-028 If FIFO is non-empty in T+1, returning data SHALL be pushed to FIFO tail; rsp_valid/rsp_rdata SHALL present the FIFO head.
REQ-029 Responses SHALL be returned strictly in read-issue order.
REQ-030 With rsp_ready held 1, back-to-back reads SHALL sustain one read per cycle, latency exactly 1 cycle.
REQ-031 Once rsp_valid=1, rsp_rdata SHALL remain stable until the rsp handshake.
REQ-032 Simultaneous FIFO push and pop SHALL leave count unchanged; FIFO SHALL never overflow (guaranteed by REQ-025).
REQ-033 A write to address A accepted after a read to A SHALL NOT alter that read's data; a read after a write to A SHALL return the written bytes.
REQ-034 idle SHALL be 1 iff occupancy = 0.

Reset
REQ-035 While rst=0: req_ready=0, rsp_valid=0, mem_write_enable=0, mem_read_enable=0, idle=1, rsp_rdata=0.
REQ-036 Reset assertion SHALL take effect asynchronously and discard the in-flight read and all FIFO entries; deassertion is synchronous to clk.
REQ-037 First cycle after reset release: req_ready=1, occupancy=0.

Verification
REQ-038 Write A=0x0010 data 0xDEADBEEF be=0xF, then read 0x0010 -> rsp_valid one cycle after read handshake, rsp_rdata=0xDEADBEEF.
REQ-039 Write 0x0010 data 0x11223344 be=0x5 over 0xDEADBEEF, read -> rsp_rdata=0xDE22BE44.
REQ-040 Four back-to-back reads of 0x0..0x3, rsp_ready=1 -> four responses in consecutive cycles, issue order, req_ready stays 1.
REQ-041 rsp_ready=0, issue reads -> exactly two accepted, req_ready=0 after second; raise rsp_ready -> both returned in order, data stable while stalled, req_ready=1 one cycle after first pop.
REQ-042 Read issued, rst driven 0 mid-cycle before data return -> rsp_valid=0 immediately, no response after release, idle=1.
REQ-043 Write and read handshakes with rsp_ready toggling randomly -> mem_*_enable never both 1, never asserted without handshake, scoreboard matches.
